sdram_init_seq: RTL and testbench

SDRAM_INIT_SEQ -- requirements
Module: sdram_init_seq

---
 rtl/sdram_defines.sv | 26 ++
 rtl/sdram_init_seq.sv | 143 ++++++++++++++
 tb/tb_sdram_init_seq.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/sdram_defines.sv
// Shared SDRAM definitions: command encodings, init-sequencer state encoding and address bit positions.
// The SDRAM controller imports this package too.
package sdram_defines;

  // Command word layout is {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_NOP          = 4'b0111;
  localparam logic [3:0] CMD_PRECHARGE    = 4'b0010;
  localparam logic [3:0] CMD_AUTO_REFRESH = 4'b0001;
  localparam logic [3:0] CMD_LOAD_MODE    = 4'b0000;

  // A10 selects all banks on PRECHARGE
  localparam int A10_BIT = 10;

  typedef enum logic [3:0] {
    ST_WAIT_LOCK,
    ST_POWERUP,
    ST_PRECHARGE,
    ST_WAIT_RP,
    ST_REFRESH,
    ST_WAIT_RFC,
    ST_LOAD_MODE,
    ST_WAIT_MRD,
    ST_DONE
  } init_state_t;

endpackage

// File: rtl/sdram_init_seq.sv
// SDRAM power-up initialisation sequencer: CKE/NOP wait, precharge-all, auto refreshes, mode register load.
// All outputs are registered and are decoded from the state being entered, so they always match the current state.
module sdram_init_seq
  import sdram_defines::*;
#(
  parameter int          POWERUP_CYCLES = 20000,
  parameter int          T_RP           = 2,
  parameter int          T_RFC          = 7,
  parameter int          T_MRD          = 2,
  parameter int          REFRESH_COUNT  = 2,
  parameter logic [11:0] MODE_REG       = 12'h032
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        locked,
  output logic        sd_cke,
  output logic [3:0]  sd_cmd,
  output logic [11:0] sd_addr,
  output logic [1:0]  sd_ba,
  output logic        init_done
);

  localparam int MAX_A  = (POWERUP_CYCLES > T_RP) ? POWERUP_CYCLES : T_RP;
  localparam int MAX_B  = (T_RFC > T_MRD) ? T_RFC : T_MRD;
  localparam int MAX_D  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW     = $clog2(MAX_D) + 1;
  localparam int RW     = $clog2(REFRESH_COUNT) + 1;

  // Wait states last T-1 cycles, so a counter loaded with T-2 expires on its last cycle
  localparam logic [CW-1:0] PU_LOAD  = CW'(POWERUP_CYCLES - 1);
  localparam logic [CW-1:0] RP_LOAD  = CW'((T_RP  > 1) ? T_RP  - 2 : 0);
  localparam logic [CW-1:0] RFC_LOAD = CW'((T_RFC > 1) ? T_RFC - 2 : 0);
  localparam logic [CW-1:0] MRD_LOAD = CW'((T_MRD > 1) ? T_MRD - 2 : 0);
  localparam logic [RW-1:0] REF_TARGET = RW'(REFRESH_COUNT);

  init_state_t     state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [RW-1:0]   ref_q, ref_d;
  logic [3:0]      cmd_d;
  logic [11:0]     addr_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_WAIT_LOCK;
      cnt_q     <= '0;
      ref_q     <= '0;
      sd_cke    <= 1'b0;
      sd_cmd    <= CMD_NOP;
      sd_addr   <= '0;
      sd_ba     <= '0;
      init_done <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ref_q     <= ref_d;
      sd_cke    <= (state_d != ST_WAIT_LOCK);
      sd_cmd    <= cmd_d;
      sd_addr   <= addr_d;
      sd_ba     <= '0;
      init_done <= (state_d == ST_DONE);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q != '0) ? cnt_q - 1'b1 : '0;
    ref_d   = ref_q;
    if (state_q != ST_WAIT_LOCK && !locked) begin
      // Losing lock anywhere restarts the whole sequence, CKE included
      state_d = ST_WAIT_LOCK;
      cnt_d   = '0;
      ref_d   = '0;
    end else begin
      case (state_q)
        ST_WAIT_LOCK: begin
          cnt_d = '0;
          ref_d = '0;
          if (locked) begin
            state_d = ST_POWERUP;
            cnt_d   = PU_LOAD;
          end
        end
        ST_POWERUP: if (cnt_q == '0) state_d = ST_PRECHARGE;
        ST_PRECHARGE: begin
          if (T_RP > 1) begin
            state_d = ST_WAIT_RP;
            cnt_d   = RP_LOAD;
          end else begin
            state_d = ST_REFRESH;
          end
        end
        ST_WAIT_RP: if (cnt_q == '0) state_d = ST_REFRESH;
        ST_REFRESH: begin
          ref_d = ref_q + 1'b1;
          if (T_RFC > 1) begin
            state_d = ST_WAIT_RFC;
            cnt_d   = RFC_LOAD;
          end else if (ref_d >= REF_TARGET) begin
            state_d = ST_LOAD_MODE;
          end else begin
            state_d = ST_REFRESH;
          end
        end
        ST_WAIT_RFC: begin
          if (cnt_q == '0) state_d = (ref_q >= REF_TARGET) ? ST_LOAD_MODE : ST_REFRESH;
        end
        ST_LOAD_MODE: begin
          if (T_MRD > 1) begin
            state_d = ST_WAIT_MRD;
            cnt_d   = MRD_LOAD;
          end else begin
            state_d = ST_DONE;
          end
        end
        ST_WAIT_MRD: if (cnt_q == '0) state_d = ST_DONE;
        ST_DONE:     cnt_d = '0;
        default: begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
          ref_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    cmd_d  = CMD_NOP;
    addr_d = '0;
    case (state_d)
      ST_PRECHARGE: begin
        cmd_d           = CMD_PRECHARGE;
        addr_d[A10_BIT] = 1'b1;
      end
      ST_REFRESH:   cmd_d = CMD_AUTO_REFRESH;
      ST_LOAD_MODE: begin
        cmd_d  = CMD_LOAD_MODE;
        addr_d = MODE_REG;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sdram_init_seq.sv
// Bench for sdram_init_seq: a nominal instance and a minimum-timing instance share clk/rst/locked,
// checked by a per-cycle vector table, a hand sequence, and a sequence-position model under random lock/reset.
module tb_sdram_init_seq;

  localparam logic [3:0] NOP = 4'b0111;
  localparam logic [3:0] PRE = 4'b0010;
  localparam logic [3:0] ARF = 4'b0001;
  localparam logic [3:0] LMR = 4'b0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        locked = 1'b0;

  logic        a_cke, b_cke;
  logic [3:0]  a_cmd, b_cmd;
  logic [11:0] a_addr, b_addr;
  logic [1:0]  a_ba, b_ba;
  logic        a_done, b_done;

  int total = 0;
  int bad   = 0;
  int cycle = 0;

  always #5 clk = ~clk;

  sdram_init_seq #(
    .POWERUP_CYCLES(10), .T_RP(2), .T_RFC(3), .T_MRD(2), .REFRESH_COUNT(2), .MODE_REG(12'h032)
  ) dut_a (
    .clk(clk), .rst(rst), .locked(locked),
    .sd_cke(a_cke), .sd_cmd(a_cmd), .sd_addr(a_addr), .sd_ba(a_ba), .init_done(a_done)
  );

  sdram_init_seq #(
    .POWERUP_CYCLES(3), .T_RP(1), .T_RFC(1), .T_MRD(1), .REFRESH_COUNT(1), .MODE_REG(12'h032)
  ) dut_b (
    .clk(clk), .rst(rst), .locked(locked),
    .sd_cke(b_cke), .sd_cmd(b_cmd), .sd_addr(b_addr), .sd_ba(b_ba), .init_done(b_done)
  );

  // Reference: position within the init sequence, counted from the first POWERUP cycle
  bit m_active = 1'b0;
  int m_k = 0;

  // Expected {cke, cmd, addr, ba, done} at position k of the sequence
  function automatic logic [19:0] model_out(int pu, int rp, int rfc, int mrd, int nref, bit act, int k);
    int j;
    if (!act) return {1'b0, NOP, 12'h000, 2'b00, 1'b0};
    j = k;
    if (j < pu) return {1'b1, NOP, 12'h000, 2'b00, 1'b0};
    j -= pu;
    if (j == 0) return {1'b1, PRE, 12'h400, 2'b00, 1'b0};
    if (j < rp) return {1'b1, NOP, 12'h000, 2'b00, 1'b0};
    j -= rp;
    if (j < nref * rfc) begin
      if (j % rfc == 0) return {1'b1, ARF, 12'h000, 2'b00, 1'b0};
      return {1'b1, NOP, 12'h000, 2'b00, 1'b0};
    end
    j -= nref * rfc;
    if (j == 0) return {1'b1, LMR, 12'h032, 2'b00, 1'b0};
    if (j < mrd) return {1'b1, NOP, 12'h000, 2'b00, 1'b0};
    return {1'b1, NOP, 12'h000, 2'b00, 1'b1};
  endfunction

  task automatic compare(input string name, input logic [19:0] got, input logic [19:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got cke=%b cmd=%b addr=%h ba=%b done=%b expected cke=%b cmd=%b addr=%h ba=%b done=%b",
               name, cycle, got[19], got[18:15], got[14:3], got[2:1], got[0],
               exp[19], exp[18:15], exp[14:3], exp[2:1], exp[0]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) m_active = 1'b0;
    else if (!m_active) begin
      if (locked) begin
        m_active = 1'b1;
        m_k = 0;
      end
    end else if (!locked) m_active = 1'b0;
    else if (m_k < 1000000) m_k++;
    #1;
    compare("model_a", {a_cke, a_cmd, a_addr, a_ba, a_done}, model_out(10, 2, 3, 2, 2, m_active, m_k));
    compare("model_b", {b_cke, b_cmd, b_addr, b_ba, b_done}, model_out(3, 1, 1, 1, 1, m_active, m_k));
    cycle++;
  endtask

  typedef struct {
    logic        rst;
    logic        locked;
    int          reps;
    logic        cke;
    logic [3:0]  cmd;
    logic [11:0] addr;
    logic        done;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic r, logic l, int n, logic cke, logic [3:0] cmd, logic [11:0] addr, logic done);
    vec_t v;
    v.rst = r; v.locked = l; v.reps = n; v.cke = cke; v.cmd = cmd; v.addr = addr; v.done = done;
    tbl.push_back(v);
  endfunction

  // Full init of the nominal instance from WAIT_LOCK with locked high, ending with n DONE cycles
  function automatic void add_init(int done_reps);
    add(0, 1, 10, 1, NOP, 12'h000, 0);
    add(0, 1, 1,  1, PRE, 12'h400, 0);
    add(0, 1, 1,  1, NOP, 12'h000, 0);
    add(0, 1, 1,  1, ARF, 12'h000, 0);
    add(0, 1, 2,  1, NOP, 12'h000, 0);
    add(0, 1, 1,  1, ARF, 12'h000, 0);
    add(0, 1, 2,  1, NOP, 12'h000, 0);
    add(0, 1, 1,  1, LMR, 12'h032, 0);
    add(0, 1, 1,  1, NOP, 12'h000, 0);
    add(0, 1, done_reps, 1, NOP, 12'h000, 1);
  endfunction

  logic [19:0] b_exp [8];

  initial begin
    // Reset, then locked held low for a long stretch
    add(1, 0, 2,  0, NOP, 12'h000, 0);
    add(0, 0, 20, 0, NOP, 12'h000, 0);
    add_init(5);
    // Reset pulse while in DONE, then full re-init
    add(1, 1, 1, 0, NOP, 12'h000, 0);
    add_init(3);
    // Lock loss in DONE, relock, then lock loss in the first WAIT_RFC cycle
    add(0, 0, 1,  0, NOP, 12'h000, 0);
    add(0, 1, 10, 1, NOP, 12'h000, 0);
    add(0, 1, 1,  1, PRE, 12'h400, 0);
    add(0, 1, 1,  1, NOP, 12'h000, 0);
    add(0, 1, 1,  1, ARF, 12'h000, 0);
    add(0, 1, 1,  1, NOP, 12'h000, 0);
    add(0, 0, 3,  0, NOP, 12'h000, 0);
    add_init(2);
    // rst and locked rising together: stay idle until rst falls
    add(1, 0, 2, 0, NOP, 12'h000, 0);
    add(1, 1, 3, 0, NOP, 12'h000, 0);
    add_init(2);

    for (int i = 0; i < tbl.size(); i++) begin
      for (int r = 0; r < tbl[i].reps; r++) begin
        rst    = tbl[i].rst;
        locked = tbl[i].locked;
        step();
        compare($sformatf("table_row%0d", i), {a_cke, a_cmd, a_addr, a_ba, a_done},
                {tbl[i].cke, tbl[i].cmd, tbl[i].addr, 2'b00, tbl[i].done});
      end
    end

    // Minimum timings: PRE, AREF and LMR back to back, then done
    b_exp[0] = {1'b1, NOP, 12'h000, 2'b00, 1'b0};
    b_exp[1] = {1'b1, NOP, 12'h000, 2'b00, 1'b0};
    b_exp[2] = {1'b1, NOP, 12'h000, 2'b00, 1'b0};
    b_exp[3] = {1'b1, PRE, 12'h400, 2'b00, 1'b0};
    b_exp[4] = {1'b1, ARF, 12'h000, 2'b00, 1'b0};
    b_exp[5] = {1'b1, LMR, 12'h032, 2'b00, 1'b0};
    b_exp[6] = {1'b1, NOP, 12'h000, 2'b00, 1'b1};
    b_exp[7] = {1'b1, NOP, 12'h000, 2'b00, 1'b1};
    rst = 1'b1;
    locked = 1'b0;
    step();
    step();
    compare("min_timing_reset", {b_cke, b_cmd, b_addr, b_ba, b_done}, {1'b0, NOP, 12'h000, 2'b00, 1'b0});
    rst = 1'b0;
    locked = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      compare($sformatf("min_timing_%0d", i), {b_cke, b_cmd, b_addr, b_ba, b_done}, b_exp[i]);
    end

    // Random lock loss and reset pulses against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 59) == 0) locked = ~locked;
      rst = ($urandom_range(0, 99) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
